fifo_ptr_ctrl: RTL
==================

# fifo_ptr_ctrl

Parametrised pointer and status controller for the synchronous FIFO. It replaces the standalone read-pointer logic with a single block that owns both read and write pointers, gates requests against full/empty, and reports occupancy, almost-full/almost-empty thresholds and error events. It sits between the requesting logic and the dual-port RAM, driving the RAM addresses and write/read strobes.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W (default 16)
- AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (range 1..2^ADDR_W)
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (range 0..2^ADDR_W-1)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- wr  input  1  write request
- rd  input  1  read request
- err_clr  input  1  clears sticky error flags
- fifo_wr  output  1  accepted write = wr & ~full (RAM write enable)
- fifo_rd  output  1  accepted read = rd & ~empty (RAM read enable)
- waddr  output  ADDR_W  RAM write address = wptr[ADDR_W-1:0]
- raddr  output  ADDR_W  RAM read address = rptr[ADDR_W-1:0]
- count  output  ADDR_W+1  occupancy, 0..2^ADDR_W
- full  output  1  count == 2^ADDR_W
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- overflow  output  1  sticky: wr while full
- underflow  output  1  sticky: rd while empty

## Operation
- Internal wptr, rptr are ADDR_W+1 bits; MSB is the wrap bit. Both increment by 1 modulo 2^(ADDR_W+1) on their accepted strobe.
- full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]); empty = (wptr == rptr).
- count = wptr - rptr, ADDR_W+1-bit unsigned subtraction (wraps correctly).
- fifo_wr/fifo_rd are combinational from inputs and current flags; no request is ever accepted beyond capacity.
- Simultaneous wr and rd:
  - neither full nor empty: both accepted, count unchanged, both pointers advance.
  - empty: only write accepted; rd rejected (underflow set if enabled).
  - full: only read accepted; wr rejected (overflow set if enabled).
- Address wrap: pointer at 2^ADDR_W-1 low bits advances to 0 with wrap bit toggled; no special handling.
- Error flags: set on the clock edge of a rejected request, held until err_clr or reset. err_clr and a new error in the same cycle: flag remains set (set wins).
- Reset (rst_n low at clock edge, including mid-operation): wptr=rptr=0, overflow=underflow=0; requests during reset cycle ignored, nothing accepted. Data in RAM is not cleared but is unreachable.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0), waddr=raddr=0, overflow=underflow=0. fifo_wr/fifo_rd follow inputs combinationally but are forced 0 while rst_n is low.
- Request to strobe: 0 cycles (combinational).
- Strobe to pointer/address/count/flag update: 1 cycle (next rising edge); all status outputs are combinational from registered pointers, glitch-free at cycle boundaries.
- No combinational path from wr/rd to any status output.

## Configuration
- FIFO_PTR_ERR_FLAGS_EN defined: overflow/underflow sticky registers and err_clr behaviour as above.
- Undefined: overflow and underflow tied to 0, err_clr ignored; pointer/flag behaviour otherwise identical.

## Test plan
- Reset: rst_n=0 one cycle with wr=rd=1 -> count=0, empty=1, fifo_wr=fifo_rd=0, no pointer movement.
- Fill (ADDR_W=4): 16 consecutive writes -> count steps 1..16, almost_full at count 14, full=1 after 16th; 17th wr -> fifo_wr=0, overflow=1 (with macro), count stays 16.
- Drain: 16 reads from full -> raddr 0..15, almost_empty at count 2, empty=1 at 0; extra rd -> fifo_rd=0, underflow=1; err_clr pulse -> underflow=0.
- Wrap: 10 writes, 10 reads, 10 writes -> waddr=4, wptr wrap bit=1, count=10, full=0.
- Simultaneous: at count=5 assert wr&rd 3 cycles -> count=5, both addresses advance by 3; at empty wr&rd -> count=1; at full wr&rd -> count=15.
- Macro off: repeat overflow/underflow stimulus -> overflow=underflow=0 throughout.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ptr_ctrl
//  Purpose  : Read/write pointer and status controller for a synchronous FIFO
//             built around a dual-port RAM. Gates requests against full/empty,
//             drives the RAM addresses and strobes, and reports occupancy,
//             almost-full/almost-empty thresholds and sticky error events.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W    RAM address width, depth = 2**ADDR_W
//    AF_LEVEL  almost_full  when count >= AF_LEVEL (1 .. 2**ADDR_W)
//    AE_LEVEL  almost_empty when count <= AE_LEVEL (0 .. 2**ADDR_W-1)
//  Ports
//    clk, rst_n          clock, synchronous active-low reset
//    wr, rd              write / read requests
//    err_clr             clears sticky overflow/underflow
//    fifo_wr, fifo_rd    accepted strobes (RAM write / read enables)
//    waddr, raddr        RAM write / read addresses
//    count               occupancy 0 .. 2**ADDR_W
//    full, empty         occupancy at capacity / zero
//    almost_full/_empty  threshold flags
//    overflow/underflow  sticky rejected-request flags
//  Configuration
//    FIFO_PTR_ERR_FLAGS_EN  when defined, overflow/underflow are sticky
//                           registers cleared by err_clr; when undefined
//                           they are tied low and err_clr is ignored.
// ============================================================================
module fifo_ptr_ctrl #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              rd,
   input  logic              err_clr,
   output logic              fifo_wr,
   output logic              fifo_rd,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W-1:0] raddr,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] c_af_level = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] c_ae_level = AE_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] c_one      = {{ADDR_W{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDR_W:0] r_wptr;
   logic [ADDR_W:0] r_rptr;

   logic w_full;
   logic w_empty;
   logic w_acc_wr;
   logic w_acc_rd;

   // Status depends only on registered pointers, never on wr/rd.
   assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
   assign w_empty = (r_wptr == r_rptr);

   // Strobes are suppressed while reset is asserted so the RAM sees nothing.
   assign w_acc_wr = rst_n & wr & ~w_full;
   assign w_acc_rd = rst_n & rd & ~w_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_acc_wr) r_wptr <= r_wptr + c_one;
         if (w_acc_rd) r_rptr <= r_rptr + c_one;
      end
   end

`ifdef FIFO_PTR_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= (r_overflow  & ~err_clr) | (wr & w_full);
         r_underflow <= (r_underflow & ~err_clr) | (rd & w_empty);
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   assign fifo_wr      = w_acc_wr;
   assign fifo_rd      = w_acc_rd;
   assign waddr        = r_wptr[ADDR_W-1:0];
   assign raddr        = r_rptr[ADDR_W-1:0];
   assign count        = r_wptr - r_rptr;   // modular subtraction handles wrap
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (count >= c_af_level);
   assign almost_empty = (count <= c_ae_level);

endmodule
`default_nettype wire
